// File: rtl/doled_arbiter_if.sv
// doled_arbiter_if: bundles the two pattern-source ports, the driver-side
// outputs and the driver busy feedback of the doled arbiter.
//   slave  : the arbiter's view (sources/driver signals in, grants/item out)
//   master : the environment's view (sources and doled driver)
interface doled_arbiter_if;
    logic       req_0;
    logic       req_1;
    logic       item_start_0;
    logic       item_start_1;
    logic [7:0] blue_0;
    logic [7:0] green_0;
    logic [7:0] red_0;
    logic [7:0] blue_1;
    logic [7:0] green_1;
    logic [7:0] red_1;
    logic [1:0] type_0;
    logic [1:0] type_1;
    logic       grant_0;
    logic       grant_1;
    logic       busy_0;
    logic       busy_1;
    logic [7:0] blue_out;
    logic [7:0] green_out;
    logic [7:0] red_out;
    logic [1:0] type_out;
    logic       led_start;
    logic       doled_busy;
    logic       timeout_flag;

    modport slave (
        input  req_0, req_1, item_start_0, item_start_1,
        input  blue_0, green_0, red_0, blue_1, green_1, red_1,
        input  type_0, type_1, doled_busy,
        output grant_0, grant_1, busy_0, busy_1,
        output blue_out, green_out, red_out, type_out,
        output led_start, timeout_flag
    );

    modport master (
        output req_0, req_1, item_start_0, item_start_1,
        output blue_0, green_0, red_0, blue_1, green_1, red_1,
        output type_0, type_1, doled_busy,
        input  grant_0, grant_1, busy_0, busy_1,
        input  blue_out, green_out, red_out, type_out,
        input  led_start, timeout_flag
    );
endinterface

// File: rtl/doled_arbiter.sv
// doled_arbiter: two-source, frame-locked arbiter in front of a doled driver.
// A source is granted for a whole frame (START ... END); each accepted item is
// latched into the output registers and announced with a 2-cycle led_start.
// Ties between the sources alternate, starting with source 0 after reset.
// Optional build macro DOLED_ARBITER_TIMEOUT_EN: forces a release after
// TIMEOUT_CYCLES owner-idle cycles and pulses timeout_flag.
module doled_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic            doled_arbiter_clk,
    input  logic            doled_arbiter_reset,
    doled_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OWNED     = 3'd1,
        START_HI  = 3'd2,
        WAIT_BUSY = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] busy_q, busy_d;
    logic       owner_q, owner_d;          // index of the granted source
    logic       last_owner_q, last_owner_d;
    logic       hi_cnt_q, hi_cnt_d;        // second led_start cycle marker
    logic       led_start_q, led_start_d;
    logic [7:0] blue_q, blue_d;
    logic [7:0] green_q, green_d;
    logic [7:0] red_q, red_d;
    logic [1:0] type_q, type_d;
    logic       owner_start_s;
    logic       timeout_hit_s;

`ifdef DOLED_ARBITER_TIMEOUT_EN
    logic [23:0] to_cnt_q, to_cnt_d;
    logic        timeout_flag_q, timeout_flag_d;
`endif

    // Only the current owner's strobe can start an item.
    assign owner_start_s = owner_q ? bus.item_start_1 : bus.item_start_0;

`ifdef DOLED_ARBITER_TIMEOUT_EN
    // Owner has been idle in OWNED for TIMEOUT_CYCLES cycles.
    assign timeout_hit_s = ((to_cnt_q + 24'd1) >= TIMEOUT_CYCLES);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state, grant and item-latch logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hi_cnt_d     = hi_cnt_q;
        blue_d       = blue_q;
        green_d      = green_q;
        red_d        = red_q;
        type_d       = type_q;
`ifdef DOLED_ARBITER_TIMEOUT_EN
        to_cnt_d       = 24'd0;
        timeout_flag_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_0 && bus.req_1) begin
                    owner_d = ~last_owner_q;
                    grant_d = last_owner_q ? 2'b01 : 2'b10;
                    state_d = OWNED;
                end else if (bus.req_0) begin
                    owner_d = 1'b0;
                    grant_d = 2'b01;
                    state_d = OWNED;
                end else if (bus.req_1) begin
                    owner_d = 1'b1;
                    grant_d = 2'b10;
                    state_d = OWNED;
                end else begin
                    grant_d = 2'b00;
                end
            end
            OWNED: begin
                if (owner_start_s) begin
                    blue_d   = owner_q ? bus.blue_1  : bus.blue_0;
                    green_d  = owner_q ? bus.green_1 : bus.green_0;
                    red_d    = owner_q ? bus.red_1   : bus.red_0;
                    type_d   = owner_q ? bus.type_1  : bus.type_0;
                    hi_cnt_d = 1'b0;
                    state_d  = START_HI;
                end else if (timeout_hit_s) begin
                    state_d = RELEASE;
`ifdef DOLED_ARBITER_TIMEOUT_EN
                    timeout_flag_d = 1'b1;
`endif
                end else begin
`ifdef DOLED_ARBITER_TIMEOUT_EN
                    to_cnt_d = to_cnt_q + 24'd1;
`endif
                    state_d = OWNED;
                end
            end
            START_HI: begin
                if (hi_cnt_q) begin
                    hi_cnt_d = 1'b0;
                    state_d  = WAIT_BUSY;
                end else begin
                    hi_cnt_d = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!bus.doled_busy) begin
                    // type 2 (END) and 3 both close the frame
                    state_d = type_q[1] ? RELEASE : OWNED;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            RELEASE: begin
                grant_d      = 2'b00;
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                grant_d  = 2'b00;
                hi_cnt_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        led_start_d = (state_d == START_HI);
        busy_d[0]   = ~((state_d == OWNED) & grant_d[0]);
        busy_d[1]   = ~((state_d == OWNED) & grant_d[1]);
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge doled_arbiter_clk) begin
        if (doled_arbiter_reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            busy_q       <= 2'b11;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            hi_cnt_q     <= 1'b0;
            led_start_q  <= 1'b0;
            blue_q       <= 8'h00;
            green_q      <= 8'h00;
            red_q        <= 8'h00;
            type_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hi_cnt_q     <= hi_cnt_d;
            led_start_q  <= led_start_d;
            blue_q       <= blue_d;
            green_q      <= green_d;
            red_q        <= red_d;
            type_q       <= type_d;
        end
    end

`ifdef DOLED_ARBITER_TIMEOUT_EN
    // Owner-idle counter and forced-release pulse.
    always_ff @(posedge doled_arbiter_clk) begin
        if (doled_arbiter_reset) begin
            to_cnt_q       <= 24'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign bus.timeout_flag = timeout_flag_q;
`else
    // No timeout hardware in this build; the parameter has no effect.
    assign bus.timeout_flag = 1'b0 & (|TIMEOUT_CYCLES);
`endif

    assign bus.grant_0   = grant_q[0];
    assign bus.grant_1   = grant_q[1];
    assign bus.busy_0    = busy_q[0];
    assign bus.busy_1    = busy_q[1];
    assign bus.led_start = led_start_q;
    assign bus.blue_out  = blue_q;
    assign bus.green_out = green_q;
    assign bus.red_out   = red_q;
    assign bus.type_out  = type_q;

endmodule

// File: doc/doled_arbiter.md
DOLED_ARBITER -- requirements
Module: doled_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd1000000: owner-idle cycles before forced release; used only when DOLED_ARBITER_TIMEOUT_EN is defined.
REQ-002 doled_arbiter_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 doled_arbiter_reset  in  1  reset, synchronous, active-high.
REQ-004 req_0, req_1  in  1 each  frame request from pattern source 0/1.
REQ-005 item_start_0, item_start_1  in  1 each  one-cycle strobe; the source's item data is valid in this cycle.
REQ-006 blue_0/green_0/red_0, blue_1/green_1/red_1  in  8 each  item color bytes.
REQ-007 type_0, type_1  in  2 each  item type: 0 START, 1 LED, 2 END; 3 is treated as END.
REQ-008 grant_0, grant_1  out  1 each  source owns the driver for the current frame.
REQ-009 busy_0, busy_1  out  1 each  item strobe is not accepted from this source.
REQ-010 blue_out, green_out, red_out  out  8 each  registered color bytes to the doled driver.
REQ-011 type_out  out  2  registered item type to the doled driver.
REQ-012 led_start  out  1  start pulse to the doled driver.
REQ-013 doled_busy  in  1  driver busy shifting an item.
REQ-014 timeout_flag  out  1  one-cycle pulse on forced release.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, OWNED, START_HI, WAIT_BUSY, RELEASE.
REQ-016 IDLE: if exactly one req_n is high, grant source n next cycle; if both are high, grant the source other than last_owner; go to OWNED.
REQ-017 grant_n SHALL stay high from OWNED entry until RELEASE completes; req_n deassertion mid-frame SHALL be ignored (frame lock).
REQ-018 OWNED: on the owner's item_start_n, latch its color and type into the *_out registers and go to START_HI; item_start from the non-owner SHALL be ignored.
REQ-019 START_HI: led_start SHALL be high for exactly 2 consecutive cycles, beginning the cycle after latch, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: stay until doled_busy is sampled low; then go to RELEASE if the latched type is END or 3, otherwise go to OWNED.
REQ-021 RELEASE (1 cycle): drop grant, set last_owner to the releasing source, return to IDLE; no grant is issued in this cycle.
REQ-022 busy_n SHALL be 0 only when the FSM is in OWNED and grant_n is 1; it is 1 in every other case, including the item-latch cycle.
REQ-023 An item_start_n arriving while busy_n is 1 SHALL be dropped with no side effect.
REQ-024 *_out SHALL hold their value from latch until the next latch, so they are stable whenever doled_busy is high.
REQ-025 Minimum item period: latch + 2 START_HI cycles + at least 1 WAIT_BUSY cycle.

Reset
REQ-026 When doled_arbiter_reset is high at a clock edge, the following SHALL take effect at that edge, including mid-item: state IDLE, grant_* 0, busy_* 1, led_start 0, *_out 0, type_out 0, timeout_flag 0, last_owner 1 (source 0 wins the first tie), timeout counter 0.
REQ-027 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-028 With DOLED_ARBITER_TIMEOUT_EN defined, a 24-bit counter SHALL count cycles spent in OWNED without an accepted item and clear on each accepted item.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the FSM SHALL go to RELEASE and pulse timeout_flag for 1 cycle; the driver receives no END item.
REQ-030 Without the macro, there SHALL be no counter, timeout_flag SHALL be tied 0, and a frame is released only by END.

Verification
REQ-031 req_0=1 only; items START, 3x LED (blue 8'h80), END -> grant_0 in the cycle after req; 5 led_start pulses of 2 cycles each; blue_out=8'h80 during the LED items; grant_0 drops after END completes.
REQ-032 req_0 and req_1 both rise together after reset -> grant_0 first; after its END, grant_1 next; repeat both together -> grant_0 (alternating).
REQ-033 While source 0 owns: item_start_1 with red_1=8'hff -> red_out unchanged, no led_start; item_start_0 while doled_busy=1 -> dropped, busy_0=1.
REQ-034 Reset asserted during START_HI -> led_start=0, grant_0=0, *_out=0 after that edge; first req afterwards grants source 0.
REQ-035 With the macro, TIMEOUT_CYCLES=16, owner sends START then stalls -> timeout_flag pulses once, grant drops, other pending requester granted; without the macro, grant is held indefinitely.
